// File: rtl/hc595_chain_ctrl_if.sv
// rtl/hc595_chain_ctrl_if.sv - frame load/ready handshake and status bundle for the 595 chain driver
interface hc595_chain_ctrl_if #(
  parameter int W = 16
) ();
  logic [W-1:0] data_in;
  logic         load;
  logic         ready;
  logic         busy;
  logic         done;

  modport master (
    output data_in,
    output load,
    input  ready,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  load,
    output ready,
    output busy,
    output done
  );
endinterface

// File: rtl/hc595_chain_ctrl.sv
// rtl/hc595_chain_ctrl.sv - daisy-chained 74HC595 serialiser with one-deep pending frame buffer
module hc595_chain_ctrl #(
  parameter int CHIP_NUM  = 2,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  hc595_chain_ctrl_if.slave   bus,
  input  logic                oe_en,
  output logic                shcp,
  output logic                stcp,
  output logic                ds,
  output logic                oe
);
  localparam int W     = 8 * CHIP_NUM;
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(W) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     sreg_q, sreg_d;
  logic [W-1:0]     pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             shcp_q, shcp_d;
  logic             stcp_q, stcp_d;
  logic             ds_q, ds_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             latched_q, latched_d;

  logic             start;
  logic [W-1:0]     start_word;
  logic [W-1:0]     shifted;

  // The bit that goes onto ds first, depending on shift direction.
  function automatic logic lead_bit(input logic [W-1:0] w);
    return (MSB_FIRST != 0) ? w[W-1] : w[0];
  endfunction

  // Next-state logic: frame sequencing, divider, pending buffer and oe gating.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    div_d      = div_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    shcp_d     = shcp_q;
    stcp_d     = stcp_q;
    ds_d       = ds_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    latched_d  = latched_q;
    oe_d       = ~(oe_en && latched_q);
    start      = 1'b0;
    start_word = bus.data_in;
    shifted    = (MSB_FIRST != 0) ? {sreg_q[W-2:0], 1'b0} : {1'b0, sreg_q[W-1:1]};

    // Loads during a running frame (but not its done cycle) park in the pending slot.
    if (busy_q && !done_q && bus.load && !pend_vld_q) begin
      pend_d     = bus.data_in;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.load && !pend_vld_q) begin
          start      = 1'b1;
          start_word = bus.data_in;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            shcp_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            shcp_d  = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = S_LATCH;
              stcp_d  = 1'b1;
            end else begin
              bit_d  = bit_q + BIT_W'(1);
              sreg_d = shifted;
              ds_d   = lead_bit(shifted);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LATCH: begin
        if (done_q) begin
          // Done cycle doubles as accept cycle 0 of the next frame.
          if (pend_vld_q) begin
            start      = 1'b1;
            start_word = pend_q;
            pend_vld_d = 1'b0;
          end else if (bus.load) begin
            start      = 1'b1;
            start_word = bus.data_in;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else if (div_q == DIV_LAST) begin
          div_d     = '0;
          stcp_d    = 1'b0;
          done_d    = 1'b1;
          latched_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (start) begin
      state_d = S_SHIFT;
      sreg_d  = start_word;
      ds_d    = lead_bit(start_word);
      shcp_d  = 1'b0;
      stcp_d  = 1'b0;
      div_d   = '0;
      phase_d = 1'b0;
      bit_d   = '0;
      busy_d  = 1'b1;
    end
  end

  // State registers; reset aborts any frame and forgets the pending one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      shcp_q     <= 1'b0;
      stcp_q     <= 1'b0;
      ds_q       <= 1'b0;
      oe_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      latched_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shcp_q     <= shcp_d;
      stcp_q     <= stcp_d;
      ds_q       <= ds_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      latched_q  <= latched_d;
    end
  end

  assign shcp      = shcp_q;
  assign stcp      = stcp_q;
  assign ds        = ds_q;
  assign oe        = oe_q;
  assign bus.ready = ~pend_vld_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// tb/tb_hc595_chain_ctrl.sv - directed self-checking bench for hc595_chain_ctrl
module tb_hc595_chain_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic oe_en = 1'b1;
  logic shcp_a, stcp_a, ds_a, oe_a;
  logic shcp_b, stcp_b, ds_b, oe_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int edges;
  logic [31:0] word;

  // per-cycle log bits: {oe, ready, busy, done, stcp, shcp, ds}
  localparam int P_DS = 0, P_SHCP = 1, P_STCP = 2, P_DONE = 3, P_BUSY = 4, P_READY = 5, P_OE = 6;
  logic [6:0] loga [0:299];
  logic [6:0] logb [0:299];

  hc595_chain_ctrl_if #(.W(16)) a_if ();
  hc595_chain_ctrl_if #(.W(8))  b_if ();

  hc595_chain_ctrl #(.CHIP_NUM(2), .CLK_DIV(2), .MSB_FIRST(1)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(a_if), .oe_en(oe_en),
    .shcp(shcp_a), .stcp(stcp_a), .ds(ds_a), .oe(oe_a)
  );

  hc595_chain_ctrl #(.CHIP_NUM(1), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(b_if), .oe_en(oe_en),
    .shcp(shcp_b), .stcp(stcp_b), .ds(ds_b), .oe(oe_b)
  );

  always #10 clk = ~clk;

  // Log both instances at the falling edge, indexed by the current cycle number.
  always @(negedge clk) begin
    if (cyc >= 0 && cyc < 300) begin
      loga[cyc] <= {oe_a, a_if.ready, a_if.busy, a_if.done, stcp_a, shcp_a, ds_a};
      logb[cyc] <= {oe_b, b_if.ready, b_if.busy, b_if.done, stcp_b, shcp_b, ds_b};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic start_window();
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  function automatic int first_at(input bit sel_b, input int pos, input bit val, input int lo, input int hi);
    logic [6:0] e;
    for (int c = lo; c <= hi; c++) begin
      e = sel_b ? logb[c] : loga[c];
      if (e[pos] == val) return c;
    end
    return -1;
  endfunction

  function automatic int count_at(input bit sel_b, input int pos, input bit val, input int lo, input int hi);
    logic [6:0] e;
    int n;
    n = 0;
    for (int c = lo; c <= hi; c++) begin
      e = sel_b ? logb[c] : loga[c];
      if (e[pos] == val) n++;
    end
    return n;
  endfunction

  // ds sampled at each shcp rising edge, first-shifted bit ends up most significant.
  function automatic logic [31:0] collect(input bit sel_b, input int lo, input int hi, output int n_edges);
    logic [6:0] e, p;
    logic [31:0] w;
    w = '0;
    n_edges = 0;
    for (int c = lo + 1; c <= hi; c++) begin
      e = sel_b ? logb[c] : loga[c];
      p = sel_b ? logb[c-1] : loga[c-1];
      if (e[P_SHCP] && !p[P_SHCP]) begin
        w = {w[30:0], e[P_DS]};
        n_edges++;
      end
    end
    return w;
  endfunction

  initial begin
    a_if.data_in = '0; a_if.load = 1'b0;
    b_if.data_in = '0; b_if.load = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle after reset
    start_window();
    run_to(10);
    check_eq("idle_outs_a", 32'(loga[9]), 32'(7'b1100000));
    check_eq("idle_outs_b", 32'(logb[9]), 32'(7'b1100000));
    check_eq("idle_no_done", count_at(0, P_DONE, 1'b1, 0, 9), 0);

    // single frame, defaults, MSB first
    start_window();
    a_if.data_in = 16'hA5C3; a_if.load = 1'b1;
    tick();
    a_if.load = 1'b0;
    run_to(80);
    word = collect(0, 0, 79, edges);
    check_eq("f1_bits", word, 32'h0000A5C3);
    check_eq("f1_edges", edges, 16);
    check_eq("f1_stcp_first", first_at(0, P_STCP, 1'b1, 0, 79), 65);
    check_eq("f1_stcp_cnt", count_at(0, P_STCP, 1'b1, 0, 79), 2);
    check_eq("f1_stcp_after", first_at(0, P_STCP, 1'b0, 65, 79), 67);
    check_eq("f1_done_first", first_at(0, P_DONE, 1'b1, 0, 79), 67);
    check_eq("f1_done_cnt", count_at(0, P_DONE, 1'b1, 0, 79), 1);
    check_eq("f1_busy_first", first_at(0, P_BUSY, 1'b1, 0, 79), 1);
    check_eq("f1_busy_end", first_at(0, P_BUSY, 1'b0, 1, 79), 68);
    check_eq("f1_oe_67", 32'(loga[67][P_OE]), 1);
    check_eq("f1_oe_low", first_at(0, P_OE, 1'b0, 0, 79), 68);

    // pending handshake
    start_window();
    a_if.data_in = 16'h00FF; a_if.load = 1'b1;
    tick();
    a_if.load = 1'b0;
    run_to(10);
    a_if.data_in = 16'hFF00; a_if.load = 1'b1;
    tick();
    a_if.load = 1'b0;
    run_to(20);
    a_if.data_in = 16'h1234; a_if.load = 1'b1;
    tick();
    a_if.load = 1'b0;
    run_to(150);
    check_eq("pd_ready_low", first_at(0, P_READY, 1'b0, 0, 149), 11);
    check_eq("pd_ready_back", first_at(0, P_READY, 1'b1, 11, 149), 68);
    check_eq("pd_done_1", first_at(0, P_DONE, 1'b1, 0, 149), 67);
    check_eq("pd_done_2", first_at(0, P_DONE, 1'b1, 68, 149), 134);
    check_eq("pd_done_cnt", count_at(0, P_DONE, 1'b1, 0, 149), 2);
    word = collect(0, 0, 66, edges);
    check_eq("pd_f1_bits", word, 32'h000000FF);
    word = collect(0, 67, 134, edges);
    check_eq("pd_f2_bits", word, 32'h0000FF00);
    check_eq("pd_f2_edges", edges, 16);
    check_eq("pd_busy_gap", count_at(0, P_BUSY, 1'b0, 1, 134), 0);
    check_eq("pd_third_ignored", count_at(0, P_BUSY, 1'b1, 135, 149), 0);

    // narrow, LSB first, CLK_DIV=1
    start_window();
    b_if.data_in = 8'h01; b_if.load = 1'b1;
    tick();
    b_if.load = 1'b0;
    run_to(25);
    word = collect(1, 0, 24, edges);
    check_eq("b_bits", word, 32'h00000080);
    check_eq("b_edges", edges, 8);
    check_eq("b_stcp_first", first_at(1, P_STCP, 1'b1, 0, 24), 17);
    check_eq("b_done_first", first_at(1, P_DONE, 1'b1, 0, 24), 18);

    // oe gating by oe_en
    check_eq("oe_on", 32'(oe_a), 0);
    oe_en = 1'b0;
    tick();
    check_eq("oe_off_next", 32'(oe_a), 1);
    oe_en = 1'b1;
    tick();
    tick();
    check_eq("oe_back_on", 32'(oe_a), 0);

    // reset mid-frame with a pending frame
    start_window();
    a_if.data_in = 16'hAAAA; a_if.load = 1'b1;
    tick();
    a_if.load = 1'b0;
    run_to(5);
    a_if.data_in = 16'h5555; a_if.load = 1'b1;
    tick();
    a_if.load = 1'b0;
    run_to(29);
    check_eq("rst_pend_ready", 32'(a_if.ready), 0);
    check_eq("rst_pre_busy", 32'(a_if.busy), 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_outs", 32'({oe_a, a_if.ready, a_if.busy, a_if.done, stcp_a, shcp_a, ds_a}),
             32'(7'b1100000));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_window();
    run_to(150);
    check_eq("rst_no_done", count_at(0, P_DONE, 1'b1, 0, 149), 0);
    check_eq("rst_no_busy", count_at(0, P_BUSY, 1'b1, 0, 149), 0);
    check_eq("rst_oe_dark", count_at(0, P_OE, 1'b0, 0, 149), 0);
    word = collect(0, 0, 149, edges);
    check_eq("rst_no_shift", edges, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
